pwm_gen_multi: RTL and testbench

//   Multi-channel PWM generator with a shared period counter and per-channel duty control.

---
 rtl/pwm_gen_multi.sv | 118 +++++++++++
 tb/tb_pwm_gen_multi.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: shared period counter, per-channel duty stepped by inc/dec edges,
// shadowed so a new duty only applies at a period boundary. Define PWM_CENTER_ALIGN_EN for up/down counting.
module pwm_gen_multi #(
  parameter int N_CH      = 2,
  parameter int WIDTH     = 8,
  parameter int PERIOD    = 10,
  parameter int STEP      = 1,
  parameter int DUTY_INIT = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_CH-1:0]         increase_duty,
  input  logic [N_CH-1:0]         decrease_duty,
  output logic [N_CH-1:0]         pwm_out,
  output logic [N_CH*WIDTH-1:0]   duty_o,
  output logic                    period_start
);

  localparam logic [WIDTH-1:0] PER_W  = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] LAST_W = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(DUTY_INIT);

  // Extra bit on the sum keeps the saturation compare from overflowing.
  function automatic logic [WIDTH-1:0] duty_up(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sum;
    sum = {1'b0, d} + {1'b0, STEP_W};
    if (sum > {1'b0, PER_W}) return PER_W;
    else                     return sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] duty_dn(input logic [WIDTH-1:0] d);
    if (d < STEP_W) return '0;
    else            return d - STEP_W;
  endfunction

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             at_start;
  logic             load_shadow;
  logic [WIDTH-1:0] duty_req [N_CH];
  logic [WIDTH-1:0] duty_act [N_CH];
  logic [N_CH-1:0]  prev_inc;
  logic [N_CH-1:0]  prev_dec;
  logic [N_CH-1:0]  inc_edge;
  logic [N_CH-1:0]  dec_edge;

  assign inc_edge = increase_duty & ~prev_inc;
  assign dec_edge = decrease_duty & ~prev_dec;

`ifdef PWM_CENTER_ALIGN_EN
  logic dir_up;
  logic dir_up_nxt;

  // Each end value is held for one extra cycle while the direction flips.
  always_comb begin
    cnt_nxt    = cnt;
    dir_up_nxt = dir_up;
    if (!en) begin
      cnt_nxt    = '0;
      dir_up_nxt = 1'b1;
    end else if (dir_up) begin
      if (cnt == LAST_W) dir_up_nxt = 1'b0;
      else               cnt_nxt    = cnt + WIDTH'(1);
    end else begin
      if (cnt == '0) dir_up_nxt = 1'b1;
      else           cnt_nxt    = cnt - WIDTH'(1);
    end
  end

  assign at_start    = (cnt == '0) && dir_up;
  assign load_shadow = !en || ((cnt == '0) && !dir_up);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_up <= 1'b1;
    else        dir_up <= dir_up_nxt;
  end
`else
  always_comb begin
    cnt_nxt = '0;
    if (en && (cnt != LAST_W)) cnt_nxt = cnt + WIDTH'(1);
  end

  assign at_start    = (cnt == '0);
  assign load_shadow = !en || (cnt == LAST_W);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
      pwm_out      <= '0;
      prev_inc     <= '0;
      prev_dec     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        duty_req[i] <= INIT_W;
        duty_act[i] <= INIT_W;
      end
    end else begin
      cnt          <= cnt_nxt;
      period_start <= en & at_start;
      prev_inc     <= increase_duty;
      prev_dec     <= decrease_duty;
      for (int i = 0; i < N_CH; i++) begin
        if (inc_edge[i] && !dec_edge[i])      duty_req[i] <= duty_up(duty_req[i]);
        else if (dec_edge[i] && !inc_edge[i]) duty_req[i] <= duty_dn(duty_req[i]);
        if (load_shadow) duty_act[i] <= duty_req[i];
        pwm_out[i] <= en && (cnt < duty_act[i]);
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_duty_o
    assign duty_o[g*WIDTH +: WIDTH] = duty_req[g];
  end

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Directed bench for pwm_gen_multi (N_CH=2, WIDTH=8, PERIOD=10, STEP=1, DUTY_INIT=5).
// Expectations switch to the up/down counter when PWM_CENTER_ALIGN_EN is defined.
module tb_pwm_gen_multi;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  increase_duty;
  logic [1:0]  decrease_duty;
  logic [1:0]  pwm_out;
  logic [15:0] duty_o;
  logic        period_start;

  int total = 0;
  int bad   = 0;
  int h0, h1, ps;

  pwm_gen_multi #(
    .N_CH(2), .WIDTH(8), .PERIOD(10), .STEP(1), .DUTY_INIT(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .increase_duty(increase_duty), .decrease_duty(decrease_duty),
    .pwm_out(pwm_out), .duty_o(duty_o), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ps(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!period_start && n < budget);
    chk("period_start_wait", 32'(period_start), 32'd1);
  endtask

  task automatic measure(input int len, output int a0, output int a1, output int p);
    a0 = 0; a1 = 0; p = 0;
    for (int i = 0; i < len; i++) begin
      a0 += int'(pwm_out[0]);
      a1 += int'(pwm_out[1]);
      p  += int'(period_start);
      tick();
    end
  endtask

  task automatic pulse(input int ch, input bit up, input int n);
    for (int k = 0; k < n; k++) begin
      if (up) increase_duty[ch] = 1'b1;
      else    decrease_duty[ch] = 1'b1;
      tick();
      increase_duty[ch] = 1'b0;
      decrease_duty[ch] = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    increase_duty = '0;
    decrease_duty = '0;
    tick();
    tick();
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_ps", 32'(period_start), 32'd0);
    chk("rst_duty", 32'(duty_o), 32'h0505);

    rst_n = 1'b1;
    en = 1'b1;
    tick();
    chk("first_ps", 32'(period_start), 32'd1);
    chk("first_pwm", 32'(pwm_out), 32'd3);

`ifdef PWM_CENTER_ALIGN_EN
    pulse(0, 1'b0, 2);
    chk("ctr_duty", 32'(duty_o), 32'h0503);
    wait_ps(50);
    measure(20, h0, h1, ps);
    chk("ctr_high0", 32'(h0), 32'd6);
    chk("ctr_high1", 32'(h1), 32'd10);
    chk("ctr_ps", 32'(ps), 32'd1);
    en = 1'b0;
    tick();
    chk("ctr_en0_pwm", 32'(pwm_out), 32'd0);
    tick();
    chk("ctr_en0_ps", 32'(period_start), 32'd0);
    en = 1'b1;
    tick();
    chk("ctr_restart_ps", 32'(period_start), 32'd1);
`else
    // Steady state at DUTY_INIT.
    measure(10, h0, h1, ps);
    chk("t1_high0", 32'(h0), 32'd5);
    chk("t1_high1", 32'(h1), 32'd5);
    chk("t1_ps", 32'(ps), 32'd1);
    chk("t1_ps_next", 32'(period_start), 32'd1);

    // Held inc gives one step; current period keeps its pulse.
    increase_duty[0] = 1'b1;
    measure(10, h0, h1, ps);
    increase_duty[0] = 1'b0;
    chk("t2_cur_high0", 32'(h0), 32'd5);
    chk("t2_duty", 32'(duty_o), 32'h0506);
    measure(10, h0, h1, ps);
    chk("t2_high0", 32'(h0), 32'd6);
    chk("t2_high1", 32'(h1), 32'd5);

    // Saturate high, then floor low.
    pulse(0, 1'b1, 7);
    chk("t3_sat_duty", 32'(duty_o), 32'h050A);
    wait_ps(30);
    measure(10, h0, h1, ps);
    chk("t3_full_high0", 32'(h0), 32'd10);
    pulse(0, 1'b0, 12);
    chk("t3_floor_duty", 32'(duty_o), 32'h0500);
    wait_ps(30);
    measure(10, h0, h1, ps);
    chk("t3_zero_high0", 32'(h0), 32'd0);

    // Simultaneous edges cancel; mid-period dec waits for the boundary.
    increase_duty[1] = 1'b1;
    decrease_duty[1] = 1'b1;
    tick();
    increase_duty[1] = 1'b0;
    decrease_duty[1] = 1'b0;
    tick();
    chk("t4_both_duty", 32'(duty_o), 32'h0500);
    wait_ps(30);
    h1 = 0;
    for (int i = 0; i < 10; i++) begin
      h1 += int'(pwm_out[1]);
      if (i == 2) decrease_duty[1] = 1'b1;
      if (i == 4) decrease_duty[1] = 1'b0;
      tick();
    end
    chk("t4_cur_high1", 32'(h1), 32'd5);
    chk("t4_dec_duty", 32'(duty_o), 32'h0400);
    measure(10, h0, h1, ps);
    chk("t4_high1", 32'(h1), 32'd4);

    // Reset mid-period while ch1 is high.
    pulse(1, 1'b1, 5);
    wait_ps(30);
    for (int i = 0; i < 6; i++) tick();
    chk("t5_pre_pwm", 32'(pwm_out), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pwm", 32'(pwm_out), 32'd0);
    chk("t5_rst_duty", 32'(duty_o), 32'h0505);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_rel_ps", 32'(period_start), 32'd1);
    measure(10, h0, h1, ps);
    chk("t5_high0", 32'(h0), 32'd5);
    chk("t5_ps", 32'(ps), 32'd1);

    // en=0 forces outputs low, duty updates still accepted.
    en = 1'b0;
    tick();
    chk("en0_pwm", 32'(pwm_out), 32'd0);
    pulse(0, 1'b1, 1);
    chk("en0_ps", 32'(period_start), 32'd0);
    chk("en0_duty", 32'(duty_o), 32'h0506);
    en = 1'b1;
    tick();
    chk("en1_ps", 32'(period_start), 32'd1);
    measure(10, h0, h1, ps);
    chk("en1_high0", 32'(h0), 32'd6);
    chk("en1_high1", 32'(h1), 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
